// File: rtl/fsm_trenes_n.sv
// Single-track interlock: round-robin grant of one shared section to N trains,
// with min/max occupancy timing, all-red clearance and a sticky timeout flag.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | section free, barrier up, waiting for any request
//   ST_GRANT | owner may proceed, barrier down, occupancy timer running
//   ST_CLEAR | all-red clearance, barrier still down, fixed CLEAR cycles
module fsm_trenes_n #(
  parameter int N         = 2,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 64,
  parameter int CLEAR     = 3,
  parameter int IDXW      = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    V,
  input  logic [N-1:0]    X,
  output logic [N-1:0]    T,
  output logic            B,
  output logic [IDXW-1:0] owner,
  output logic [1:0]      status,
  output logic            fault
);

  // Counter also has to reach CLEAR-1, so size it for the larger of the two.
  localparam int CMAX = (MAX_GREEN > CLEAR) ? MAX_GREEN : CLEAR;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] MIN_LAST   = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_LAST   = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_CLEAR = 2'b10
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [IDXW-1:0] ptr, ptr_nx;
  logic [IDXW-1:0] owner_nx;
  logic [IDXW-1:0] pick;
  logic            found;
  logic            fault_nx;
  logic            exit_ok;
  logic [N-1:0]    t_nx;
  logic            b_nx;
  int              j;

  // Round-robin search: first requester at or above the pointer, wrapping mod N.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && V[j]) begin
        found = 1'b1;
        pick  = IDXW'(j);
      end
    end
  end

  assign exit_ok = X[owner] && (cnt >= MIN_LAST);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    owner_nx = owner;
    fault_nx = fault;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_nx = ST_GRANT;
          owner_nx = pick;
          ptr_nx   = (int'(pick) == N - 1) ? '0 : pick + IDXW'(1);
          cnt_nx   = '0;
        end
      end
      ST_GRANT: begin
        // An exit on the timeout cycle wins over the timeout.
        if (exit_ok) begin
          state_nx = ST_CLEAR;
          cnt_nx   = '0;
        end else if (cnt == MAX_LAST) begin
          state_nx = ST_CLEAR;
          fault_nx = 1'b1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      ST_CLEAR: begin
        if (cnt == CLEAR_LAST) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    t_nx = '0;
    if (state_nx == ST_GRANT) t_nx[owner_nx] = 1'b1;
    b_nx = (state_nx != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ptr   <= '0;
      owner <= '0;
      fault <= 1'b0;
      T     <= '0;
      B     <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ptr   <= ptr_nx;
      owner <= owner_nx;
      fault <= fault_nx;
      T     <= t_nx;
      B     <= b_nx;
    end
  end

  assign status = state;

endmodule

// File: tb/tb_fsm_trenes_n.sv
// Bench for fsm_trenes_n (N=2): vector table plus hand-written corner sequences,
// expected outputs queued at drive time and compared after each rising edge.
module tb_fsm_trenes_n;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] V = 2'b00;
  logic [1:0] X = 2'b00;
  logic [1:0] T;
  logic       B;
  logic [0:0] owner;
  logic [1:0] status;
  logic       fault;

  always #5 clk = ~clk;

  fsm_trenes_n #(.N(N), .MIN_GREEN(4), .MAX_GREEN(64), .CLEAR(3)) dut (
    .clk(clk), .reset(reset), .V(V), .X(X),
    .T(T), .B(B), .owner(owner), .status(status), .fault(fault)
  );

  typedef struct {
    logic       rst;
    logic [1:0] v;
    logic [1:0] x;
    logic [1:0] t;
    logic       b;
    logic       o;
    logic [1:0] st;
    logic       f;
    int         tag;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  vec_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   seq_tag = 1000;

  function automatic vec_t mk(logic rst, logic [1:0] v, logic [1:0] x, logic [1:0] t,
                              logic b, logic o, logic [1:0] st, logic f);
    vec_t e;
    e.rst = rst; e.v = v; e.x = x; e.t = t;
    e.b = b; e.o = o; e.st = st; e.f = f; e.tag = 0;
    return e;
  endfunction

  function automatic void add(vec_t e);
    e.tag = vecs.size();
    vecs.push_back(e);
  endfunction

  // Row helpers for the three states and for reset; o is the expected owner.
  function automatic void add_g(int n, logic [1:0] v, logic [1:0] x, logic o, logic f);
    for (int i = 0; i < n; i++) add(mk(1'b0, v, x, o ? 2'b10 : 2'b01, 1'b1, o, 2'b01, f));
  endfunction
  function automatic void add_c(int n, logic [1:0] v, logic [1:0] x, logic o, logic f);
    for (int i = 0; i < n; i++) add(mk(1'b0, v, x, 2'b00, 1'b1, o, 2'b10, f));
  endfunction
  function automatic void add_i(int n, logic [1:0] v, logic [1:0] x, logic o, logic f);
    for (int i = 0; i < n; i++) add(mk(1'b0, v, x, 2'b00, 1'b0, o, 2'b00, f));
  endfunction
  function automatic void add_r(int n, logic [1:0] v, logic [1:0] x);
    for (int i = 0; i < n; i++) add(mk(1'b1, v, x, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0));
  endfunction

  task automatic step(vec_t e);
    @(negedge clk);
    reset = e.rst;
    V     = e.v;
    X     = e.x;
    sb.push_back(e);
  endtask

  task automatic hstep(logic rst, logic [1:0] v, logic [1:0] x, logic [1:0] t,
                       logic b, logic o, logic [1:0] st, logic f);
    vec_t e;
    e = mk(rst, v, x, t, b, o, st, f);
    e.tag = seq_tag;
    seq_tag++;
    step(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (T !== mon_e.t || B !== mon_e.b || owner !== mon_e.o ||
          status !== mon_e.st || fault !== mon_e.f) begin
        failures++;
        $display("FAIL vec%0d: got T=%b B=%b owner=%0d status=%b fault=%b, want T=%b B=%b owner=%0d status=%b fault=%b",
                 mon_e.tag, T, B, owner, status, fault,
                 mon_e.t, mon_e.b, mon_e.o, mon_e.st, mon_e.f);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with all requests and exits active.
    add_r(2, 2'b11, 2'b11);
    // Round-robin: train 0 first, exit pulsed on GRANT cycle 4, then train 1.
    add_g(5, 2'b11, 2'b00, 1'b0, 1'b0);
    add_c(1, 2'b11, 2'b01, 1'b0, 1'b0);
    add_c(2, 2'b11, 2'b00, 1'b0, 1'b0);
    add_i(1, 2'b11, 2'b00, 1'b0, 1'b0);
    add_g(1, 2'b11, 2'b00, 1'b1, 1'b0);
    // Minimum green with exit held from the first GRANT cycle, train 1 then train 0.
    add_g(3, 2'b01, 2'b10, 1'b1, 1'b0);
    add_c(3, 2'b01, 2'b10, 1'b1, 1'b0);
    add_i(1, 2'b01, 2'b00, 1'b1, 1'b0);
    add_g(4, 2'b01, 2'b01, 1'b0, 1'b0);
    add_c(3, 2'b00, 2'b01, 1'b0, 1'b0);
    add_i(1, 2'b00, 2'b00, 1'b0, 1'b0);
    // Non-owner exit pulses and dropped request leave the grant untouched.
    add_g(1, 2'b01, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      add_g(1, 2'b00, 2'b10, 1'b0, 1'b0);
      add_g(1, 2'b00, 2'b00, 1'b0, 1'b0);
    end
    add_c(1, 2'b00, 2'b01, 1'b0, 1'b0);
    add_c(2, 2'b00, 2'b00, 1'b0, 1'b0);
    add_i(1, 2'b00, 2'b00, 1'b0, 1'b0);
    // Timeout after 64 GRANT cycles; fault then sticks through a normal grant.
    add_g(64, 2'b01, 2'b00, 1'b0, 1'b0);
    add_c(3, 2'b01, 2'b00, 1'b0, 1'b1);
    add_i(1, 2'b00, 2'b00, 1'b0, 1'b1);
    add_g(1, 2'b10, 2'b00, 1'b1, 1'b1);
    add_g(3, 2'b10, 2'b10, 1'b1, 1'b1);
    add_c(3, 2'b00, 2'b10, 1'b1, 1'b1);
    add_i(1, 2'b00, 2'b00, 1'b1, 1'b1);
    // Reset mid-GRANT at counter 10; pointer must return to train 0.
    add_r(1, 2'b11, 2'b00);
    add_g(11, 2'b11, 2'b00, 1'b0, 1'b0);
    add_r(1, 2'b11, 2'b00);
    add_g(1, 2'b11, 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Exit arriving on the timeout cycle is an exit, not a fault.
    repeat (63) hstep(1'b0, 2'b11, 2'b00, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0);
    hstep(1'b0, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0);
    hstep(1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0);
    hstep(1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0);
    hstep(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    // Both waiting: pointer now favours train 1.
    hstep(1'b0, 2'b11, 2'b00, 2'b10, 1'b1, 1'b1, 2'b01, 1'b0);
    repeat (3) hstep(1'b0, 2'b11, 2'b10, 2'b10, 1'b1, 1'b1, 2'b01, 1'b0);
    hstep(1'b0, 2'b11, 2'b10, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0);
    hstep(1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0);
    // Reset mid-CLEAR, then train 0 wins again from the reset pointer.
    hstep(1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    hstep(1'b0, 2'b11, 2'b00, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0);

    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
